// File: rtl/addr_chaser_4b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addr_chaser_4b_pkg
//  Brief    : Shared mode and direction encodings for the LED address chaser.
//  Revision : 1.0  initial release
// ============================================================================
package addr_chaser_4b_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP     = 2'b00;
    localparam mode_t MODE_DOWN   = 2'b01;
    localparam mode_t MODE_PING   = 2'b10;
    localparam mode_t MODE_MANUAL = 2'b11;

    // Direction values double as the ping-pong FSM state encoding.
    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

endpackage : addr_chaser_4b_pkg
`default_nettype wire

// File: rtl/addr_chaser_4b_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Brief    : Prescaler counting 0..PRESCALE-1; pulses tick_o at terminal count.
//  Revision : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int PRESCALE = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_at_term;

    assign w_at_term = (cnt_q == C_TERM);
    // Tick is combinational so the consumer's registers see it in the same cycle.
    assign tick_o    = enable_i & ~clear_i & w_at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = w_at_term ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/addr_chaser_4b.sv
`default_nettype none
// ============================================================================
//  Module   : addr_chaser_4b
//  Brief    : 4-bit walking address sequencer (up/down/ping-pong/manual) that
//             feeds a 4-to-16 one-hot LED decoder.
//  Revision : 1.0  initial release
// ============================================================================
module addr_chaser_4b
    import addr_chaser_4b_pkg::*;
#(
    parameter int PRESCALE = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       run_i,
    input  logic [1:0] mode_i,
    input  logic       step_i,
    input  logic       blank_i,
    output logic       en_o,
    output logic [3:0] a_o,
    output logic       dir_o,
    output logic       tick_o
);

    mode_t       mode_q;
    logic        step_q;
    logic [0:0]  pp_q;
    logic [0:0]  pp_d;
    logic [3:0]  a_q;
    logic [3:0]  a_d;
    logic        dir_q;
    logic        dir_d;
    logic        en_q;
    logic        tick_q;

    logic        w_mode_chg;
    logic        w_manual;
    logic        w_step_rise;
    logic        w_tg_tick;
    logic        w_advance;

    assign w_mode_chg  = (mode_q != mode_i);
    assign w_manual    = (mode_q == MODE_MANUAL);
    assign w_step_rise = step_i & ~step_q;

    tick_gen #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (run_i & ~w_manual),
        .clear_i  (w_mode_chg | w_manual),
        .tick_o   (w_tg_tick)
    );

    // A mode change swallows any coincident terminal count or step edge.
    assign w_advance = ~w_mode_chg & (w_manual ? w_step_rise : w_tg_tick);

    always_comb begin
        a_d  = a_q;
        pp_d = pp_q;
        if (w_mode_chg) begin
            if (mode_i == MODE_PING) begin
                pp_d = (a_q == 4'hF) ? DIR_DOWN : DIR_UP;
            end
        end else if (w_advance) begin
            case (mode_q)
                MODE_DOWN: a_d = a_q - 4'd1;
                MODE_PING: begin
                    if (pp_q == DIR_UP) begin
                        a_d = a_q + 4'd1;
                        if (a_q == 4'd14) pp_d = DIR_DOWN;
                    end else begin
                        a_d = a_q - 4'd1;
                        if (a_q == 4'd1) pp_d = DIR_UP;
                    end
                end
                default:   a_d = a_q + 4'd1;
            endcase
        end
    end

    // mode_i equals mode_q except on a change, where it is the mode being entered.
    always_comb begin
        dir_d = DIR_UP;
        case (mode_i)
            MODE_DOWN: dir_d = DIR_DOWN;
            MODE_PING: dir_d = pp_d;
            default:   dir_d = DIR_UP;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mode_q <= MODE_UP;
            step_q <= 1'b0;
            pp_q   <= DIR_UP;
            a_q    <= 4'd0;
            dir_q  <= 1'b0;
            en_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_i;
            step_q <= step_i;
            pp_q   <= pp_d;
            a_q    <= a_d;
            dir_q  <= dir_d;
            en_q   <= ~blank_i;
            tick_q <= w_advance;
        end
    end

    assign en_o   = en_q;
    assign a_o    = a_q;
    assign dir_o  = dir_q;
    assign tick_o = tick_q;

endmodule : addr_chaser_4b
`default_nettype wire

// File: doc/addr_chaser_4b.md
# addr_chaser_4b

Free-running 4-bit address sequencer that drives the `en`/`a[3:0]` inputs of the board's 4-to-16 one-hot decoder. It produces a walking-LED pattern: count up, count down, ping-pong, or manual single-step. A programmable prescaler sets the step rate. The block is the stage directly upstream of the decoder; the decoder's 16 outputs go straight to the LEDs.

## Interface
- `PRESCALE`, default 25_000_000: clock cycles per automatic step; legal range ≥ 1.
- `CNT_W`, default 25: prescaler counter width; must satisfy 2^CNT_W ≥ PRESCALE.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset; one clock, asynchronous active-high reset (fixed).
- `run`  in  1  level; 1 = automatic stepping enabled (ignored in manual mode).
- `mode`  in  2  00 up, 01 down, 10 ping-pong, 11 manual.
- `step`  in  1  manual step request, synchronous to `clk`, already debounced; acts on rising edge.
- `blank`  in  1  level; 1 forces decoder disable.
- `en`  out  1  registered decoder enable (= ~blank, one cycle late).
- `a`  out  4  registered decoder address.
- `dir`  out  1  current direction: 0 up, 1 down.
- `tick`  out  1  one-cycle pulse coincident with each new value on `a`.

## Operation
- Reset values: `a`=0, `en`=0, `dir`=0, `tick`=0, prescaler=0, step edge register=0, mode register=00.
- Prescaler: counts 0..PRESCALE-1 while `run`=1 and mode≠11.
  - At PRESCALE-1 it wraps to 0 and issues an internal advance.
  - `run`=0 holds the count (no clear).
  - In mode 11 the count is held at 0.
- Mode 00: `a` ← `a`+1 mod 16 per advance (15→0 wraps); `dir`=0.
- Mode 01: `a` ← `a`−1 mod 16 per advance (0→15 wraps); `dir`=1.
- Mode 10 (ping-pong), two states, UP and DOWN, with `dir` equal to the state:
  - UP: `a`+1. When `a`=14 advances to 15, the state becomes DOWN.
  - DOWN: `a`−1. When `a`=1 advances to 0, the state becomes UP.
  - Resulting sequence: 0,1,…,15,14,…,0,1,… Each endpoint appears once per bounce.
- Mode 11 (manual):
  - Each 0→1 transition of `step` (`step`=1 and previous-cycle `step`=0) advances `a`+1 mod 16.
  - `run` is ignored; `dir`=0.
- Mode change (registered `mode` ≠ input `mode`):
  - The prescaler clears to 0 and `a` holds.
  - No advance occurs in that cycle, even if a terminal count or step edge coincides.
  - On entry to mode 10, the state is UP, or DOWN if `a`=15.
- `blank`: does not stop sequencing; it only drives `en`=0.
- `tick`: pulses for every change of `a` caused by an advance. It never pulses on a mode change or on reset.

## Timing
- Terminal count or step edge sampled in cycle N → new `a`, `dir`, and `tick`=1 visible in cycle N+1; `tick` returns to 0 in cycle N+2 unless another advance occurs.
- PRESCALE=1: an advance on every cycle while running; `tick` stays high continuously.
- Automatic step period is exactly PRESCALE cycles. Holding `run` low for k cycles delays the next advance by exactly k cycles.
- `blank` → `en`: 1 cycle latency.
- Reset asserted mid-sequence: all outputs go to their reset values immediately, independent of `clk`. The first automatic advance after deassertion occurs PRESCALE cycles after the first rising edge with `reset`=0 and `run`=1.
- `step` held high: exactly one advance. `step` high during the cycle reset deasserts: no advance (edge register resets to 0 and then loads 1… the required behaviour is no advance).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package or include file holds:
  - mode encodings `MODE_UP`=2'b00, `MODE_DOWN`=2'b01, `MODE_PING`=2'b10, `MODE_MANUAL`=2'b11;
  - direction encodings `DIR_UP`=0, `DIR_DOWN`=1.
- One sub-module, `tick_gen`: parameterised prescaler (`PRESCALE`, `CNT_W`) with inputs `enable` and `clear` and output `tick`. It is reused by other timed blocks in the design.
- The top-level module contains the edge detector, the mode register, the ping-pong state machine and the output registers.

## Test plan
All scenarios use `PRESCALE`=4.
- Reset, then `mode`=00 and `run`=1 for 70 cycles → `a` reads 0,1,2,…,15,0,1; one step every 4 cycles; `tick` is high for 1 cycle at each change; `en`=1 from cycle 2 on.
- `mode`=10 starting from `a`=0 → `a` reads 0..15,14..0,1; `dir` goes to 1 on the cycle `a`=15 appears and returns to 0 on the cycle `a`=0 appears.
- `mode`=01 from `a`=0 → `a` reads 15,14,13; `dir`=1; `run`=0 for 10 cycles mid-period → the next step is delayed by exactly 10 cycles.
- `mode`=11 with `step` pulses of 1, 5 and 3 cycles → `a` advances by exactly 3 in total; `run` toggling has no effect.
- Mode change from 00 to 10 in the same cycle as a terminal count with `a`=15 → no advance, state DOWN, next `a`=14 appears 4 cycles later.
- `blank`=1 while running → `en`=0 one cycle later and `a` keeps counting; `reset` pulsed mid-count → `a`=0, `en`=0, `tick`=0 immediately.
